// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite OAM DMA engine; copies one 256-byte page to the OAM data port.
// Latency: rdy drops the cycle after the trigger write and stays low for 513 cycles, or 514 when an align cycle is needed.
// Backpressure: none on the memory side; the CPU is stalled through rdy while the engine owns the bus.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cpu_addr/cpu_dout/cpu_r_w_n    CPU bus request (driven onto the shared bus when idle)
//   bus_din                        memory read data, valid in the cycle bus_addr is presented
//   bus_addr/bus_dout/bus_r_w_n    shared memory bus
//   rdy                            CPU ready (0 = CPU halted)
//   busy                           engine active
// Optional feature: define DMA_ALIGN_EN to insert an align cycle when the halt lands on an odd cycle.

module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_PORT_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_r_w_n,
  input  logic [7:0]  bus_din,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_r_w_n,
  output logic        rdy,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state_q;
  logic [7:0]  page_q;
  logic [7:0]  idx_q;
  logic [7:0]  data_q;
  logic        trigger;
  logic        align_req;

  // Only a CPU write to the DMA register while idle starts a transfer.
  assign trigger = (state_q == S_IDLE) && !cpu_r_w_n && (cpu_addr == DMA_REG_ADDR);

`ifdef DMA_ALIGN_EN
  logic cycle_odd_q;

  // Free-running parity of the cycle count since reset.
  always_ff @(posedge clk) begin
    if (reset) cycle_odd_q <= 1'b0;
    else       cycle_odd_q <= ~cycle_odd_q;
  end

  assign align_req = cycle_odd_q;
`else
  assign align_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            page_q  <= cpu_dout;
            idx_q   <= 8'h00;
            state_q <= S_HALT;
          end
        end
        S_HALT:  state_q <= align_req ? S_ALIGN : S_READ;
        S_ALIGN: state_q <= S_READ;
        S_READ: begin
          data_q  <= bus_din;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          idx_q   <= idx_q + 8'd1;
          // Last byte of the page written: hand the bus back.
          state_q <= (idx_q == 8'hFF) ? S_IDLE : S_READ;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Status is a pure decode of the state register, so it changes only on clock edges.
  assign busy = (state_q != S_IDLE);
  assign rdy  = ~busy;

  // Bus mux: CPU passes straight through when idle; otherwise the engine drives.
  always_comb begin
    bus_addr  = cpu_addr;
    bus_dout  = cpu_dout;
    bus_r_w_n = cpu_r_w_n;
    case (state_q)
      S_HALT, S_ALIGN, S_READ: begin
        // Halt/align cycles issue a harmless dummy read of the next source byte.
        bus_addr  = {page_q, idx_q};
        bus_dout  = 8'h00;
        bus_r_w_n = 1'b1;
      end
      S_WRITE: begin
        bus_addr  = OAM_PORT_ADDR;
        bus_dout  = data_q;
        bus_r_w_n = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
